// File: rtl/divider_job_scheduler.sv
// divider_job_scheduler: shares one divider core between up to four requesters.
// Round-robin arbitration picks a requester, the operand pair is latched and
// issued, and the quotient/remainder (or a timeout error) is returned to the
// granted channel. Only one operation is ever in flight.
//
// Optional feature: define DIV_SCHED_ZERO_BYPASS_EN to answer a zero divisor
// directly (all-ones quotient, dividend as remainder, error flagged) without
// starting the divider. Without the macro a zero divisor is issued normally.
module divider_job_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 48,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*2*DATA_W-1:0] req_data,
  output logic                        div_start,
  output logic [2*DATA_W-1:0]         div_operands,
  input  logic                        div_done,
  input  logic [2*DATA_W-1:0]         div_result,
  output logic [NUM_REQ-1:0]          rsp_valid,
  input  logic [NUM_REQ-1:0]          rsp_ready,
  output logic [2*DATA_W-1:0]         rsp_data,
  output logic                        rsp_err,
  output logic                        busy,
  output logic [1:0]                  grant_id
);

  localparam int PAIR_W = 2 * DATA_W;
  localparam int CNT_W  = 16;
  localparam logic [1:0] LAST_GRANT_RST = 2'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          last_grant_q, last_grant_d;
  logic [1:0]          grant_id_q, grant_id_d;
  logic [PAIR_W-1:0]   operands_q, operands_d;
  logic [PAIR_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;

  logic                grant_found;
  logic [1:0]          grant_idx;
  logic [1:0]          cand;
  logic [NUM_REQ-1:0]  req_ready_c;
  logic [NUM_REQ-1:0]  rsp_valid_c;
  logic                div_start_c;

`ifdef DIV_SCHED_ZERO_BYPASS_EN
  logic                divisor_zero;
  assign divisor_zero = (operands_q[DATA_W-1:0] == '0);
`endif

  // Round-robin search: first valid channel above the last granted one.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_grant_q;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = 2'((int'(last_grant_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Next-state logic and per-state outputs of the scheduling FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    operands_d   = operands_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    req_ready_c  = '0;
    rsp_valid_c  = '0;
    div_start_c  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          req_ready_c[grant_idx] = 1'b1;
          operands_d             = req_data[grant_idx*PAIR_W +: PAIR_W];
          grant_id_d             = grant_idx;
          state_d                = S_ISSUE;
        end
      end

      S_ISSUE: begin
        cnt_d = '0;
`ifdef DIV_SCHED_ZERO_BYPASS_EN
        if (divisor_zero) begin
          rsp_data_d = {{DATA_W{1'b1}}, operands_q[PAIR_W-1:DATA_W]};
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end else begin
          div_start_c = 1'b1;
          state_d     = S_WAIT;
        end
`else
        div_start_c = 1'b1;
        state_d     = S_WAIT;
`endif
      end

      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A completion in the timeout cycle still counts as a real result.
        if (div_done) begin
          rsp_data_d = div_result;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (cnt_q == TIMEOUT_VAL) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end
      end

      S_RESP: begin
        rsp_valid_c[grant_id_q] = 1'b1;
        if (rsp_ready[grant_id_q]) begin
          last_grant_d = grant_id_q;
          state_d      = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_grant_q <= LAST_GRANT_RST;
      grant_id_q   <= '0;
      operands_q   <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      operands_q   <= operands_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // The accept strobe is combinational from req_valid, so it is masked while
  // reset is held to keep every output low during reset.
  assign req_ready    = req_ready_c & {NUM_REQ{rst_n}};
  assign rsp_valid    = rsp_valid_c;
  assign div_start    = div_start_c;
  assign div_operands = operands_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_err      = rsp_err_q;
  assign busy         = (state_q != S_IDLE);
  assign grant_id     = grant_id_q;

endmodule

// File: tb/tb_divider_job_scheduler.sv
// Bench for divider_job_scheduler: behavioural divider with programmable
// latency, scoreboard of expected responses, one task per scenario.
module tb_divider_job_scheduler;

  localparam int NR = 4;
  localparam int DW = 48;
  localparam int PW = 2 * DW;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_ready;
  logic [NR*PW-1:0] req_data = '0;
  logic            div_start;
  logic [PW-1:0]   div_operands;
  logic            div_done;
  logic [PW-1:0]   div_result;
  logic [NR-1:0]   rsp_valid;
  logic [NR-1:0]   rsp_ready = '0;
  logic [PW-1:0]   rsp_data;
  logic            rsp_err;
  logic            busy;
  logic [1:0]      grant_id;

  divider_job_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .div_start(div_start), .div_operands(div_operands),
    .div_done(div_done), .div_result(div_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            ch;
    logic [PW-1:0] data;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int rdy_pulses = 0;
  int start_pulses = 0;

  // Divider behaviour: zero divisor yields zero, otherwise {quotient, remainder}.
  function automatic logic [PW-1:0] div_model(input logic [PW-1:0] ops);
    logic [DW-1:0] a, b;
    a = ops[PW-1:DW];
    b = ops[DW-1:0];
    if (b == '0) return '0;
    return {a / b, a % b};
  endfunction

  // Divider model: done pulses div_lat cycles after the start strobe.
  int            div_lat = 5;
  int            m_off = 0;
  bit            m_busy = 1'b0;
  logic          model_done = 1'b0;
  logic          stray_done = 1'b0;
  logic [PW-1:0] m_res = '0;
  assign div_done   = model_done | stray_done;
  assign div_result = m_res;

  always @(posedge clk) begin
    model_done <= 1'b0;
    if (div_start) begin
      m_res <= div_model(div_operands);
      m_off <= 1;
      m_busy <= (div_lat != 1);
      if (div_lat == 1) model_done <= 1'b1;
    end else if (m_busy) begin
      m_off <= m_off + 1;
      if (m_off + 1 == div_lat) begin
        m_busy <= 1'b0;
        model_done <= 1'b1;
      end
    end
  end

  // Pulse counters for accept and start strobes.
  always @(posedge clk) begin
    if (rst_n) begin
      rdy_pulses   <= rdy_pulses + $countones(req_ready);
      start_pulses <= start_pulses + int'(div_start);
    end
  end

  task automatic wait_rsp(input int bound, output int n, output bit ok);
    n = 0;
    while (rsp_valid == '0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    ok = (rsp_valid != '0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if ({req_ready, rsp_valid, div_start} !== '0) begin errors++;
      $display("FAIL reset_strobes: got ready=%b valid=%b start=%b want 0", req_ready, rsp_valid, div_start); end
    checks++; if (div_operands !== '0 || rsp_data !== '0 || rsp_err !== 1'b0) begin errors++;
      $display("FAIL reset_data: got ops=%h data=%h err=%b want 0", div_operands, rsp_data, rsp_err); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    exp_t e;
    int n, base;
    bit ok;
    div_lat = 2;
    base = rdy_pulses;
    for (int ch = 0; ch < NR; ch++) req_data[ch*PW +: PW] = {48'(1000 + ch*37), 48'(3 + ch)};
    for (int k = 0; k < 5; k++) begin
      e.ch = k % NR; e.data = div_model(req_data[(k % NR)*PW +: PW]); e.err = 1'b0;
      exp_q.push_back(e);
    end
    rsp_ready = 4'hF;
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_rsp(20, n, ok);
      e = exp_q.pop_front();
      checks++; if (!ok) begin errors++; $display("FAIL rr_rsp_timeout: got no rsp_valid want ch%0d", e.ch); end
      checks++; if (rsp_valid !== 4'(1 << e.ch)) begin errors++; $display("FAIL rr_order: got rsp_valid=%b want ch%0d", rsp_valid, e.ch); end
      checks++; if (rsp_data !== e.data) begin errors++; $display("FAIL rr_data: got %h want %h", rsp_data, e.data); end
      checks++; if (grant_id !== 2'(e.ch)) begin errors++; $display("FAIL rr_grant_id: got %0d want %0d", grant_id, e.ch); end
      if (k == 4) req_valid = '0;
      @(negedge clk);
    end
    rsp_ready = '0;
    checks++; if (rdy_pulses - base !== 5) begin errors++; $display("FAIL rr_accepts: got %0d want 5", rdy_pulses - base); end
  endtask

  task automatic test_single();
    exp_t e;
    int n, base;
    bit ok;
    div_lat = 5;
    base = rdy_pulses;
    @(negedge clk);
    req_data[2*PW +: PW] = {48'd100, 48'd7};
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    checks++; if (div_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b want 1", div_start); end
    checks++; if (div_operands !== {48'd100, 48'd7}) begin errors++; $display("FAIL single_ops: got %h", div_operands); end
    e.ch = 2; e.data = {48'd14, 48'd2}; e.err = 1'b0;
    exp_q.push_back(e);
    wait_rsp(30, n, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || n != 6) begin errors++; $display("FAIL single_latency: got %0d cycles want 6 after start", n); end
    checks++; if (rsp_valid !== 4'(1 << e.ch)) begin errors++; $display("FAIL single_valid: got %b want 0100", rsp_valid); end
    checks++; if (rsp_data !== e.data || rsp_err !== e.err) begin errors++;
      $display("FAIL single_data: got %h err=%b want %h err=%b", rsp_data, rsp_err, e.data, e.err); end
    checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_grant_id: got %0d want 2", grant_id); end
    rsp_ready = 4'b0100;
    @(negedge clk);
    rsp_ready = '0;
    checks++; if (busy !== 1'b0 || rsp_valid !== '0) begin errors++; $display("FAIL single_release: got busy=%b valid=%b want 0", busy, rsp_valid); end
    checks++; if (rdy_pulses - base !== 1) begin errors++; $display("FAIL single_ready_pulses: got %0d want 1", rdy_pulses - base); end
  endtask

  task automatic test_timeout();
    exp_t e;
    int n, bad;
    bit ok;
    div_lat = 12;
    @(negedge clk);
    req_data[1*PW +: PW] = {48'd50, 48'd5};
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = '0;
    checks++; if (div_start !== 1'b1) begin errors++; $display("FAIL to_start: got %b want 1", div_start); end
    e.ch = 1; e.data = '0; e.err = 1'b1;
    exp_q.push_back(e);
    wait_rsp(40, n, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || n != TO + 2) begin errors++; $display("FAIL to_latency: got %0d cycles want %0d", n, TO + 2); end
    checks++; if (rsp_valid !== 4'(1 << e.ch)) begin errors++; $display("FAIL to_valid: got %b want 0010", rsp_valid); end
    checks++; if (rsp_data !== e.data || rsp_err !== e.err) begin errors++;
      $display("FAIL to_data: got %h err=%b want 0 err=1", rsp_data, rsp_err); end
    rsp_ready = 4'b0010;
    @(negedge clk);
    rsp_ready = '0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy !== 1'b0 || rsp_valid !== '0) bad++;
    end
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (busy !== 1'b0 || rsp_valid !== '0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL to_late_done: got %0d active cycles want 0", bad); end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int n, base, bad;
    bit ok;
    div_lat = 3;
    @(negedge clk);
    req_data[0 +: PW] = {48'd900, 48'd11};
    req_valid = 4'b0001;
    @(negedge clk);
    req_data[1*PW +: PW] = {48'd5, 48'd1};
    req_data[3*PW +: PW] = {48'd6, 48'd2};
    req_valid = 4'b1010;
    base = rdy_pulses;
    e.ch = 0; e.data = {48'd81, 48'd9}; e.err = 1'b0;
    exp_q.push_back(e);
    wait_rsp(30, n, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || rsp_valid !== 4'b0001 || rsp_data !== e.data) begin errors++;
      $display("FAIL bp_first: got valid=%b data=%h want 0001 %h", rsp_valid, rsp_data, e.data); end
    rsp_ready = 4'b1110;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid !== 4'b0001 || rsp_data !== e.data || rsp_err !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles want 0", bad); end
    checks++; if (rdy_pulses - base !== 0) begin errors++; $display("FAIL bp_other_ready: got %0d pulses want 0", rdy_pulses - base); end
    req_valid = '0;
    rsp_ready = 4'b0001;
    @(negedge clk);
    rsp_ready = '0;
    checks++; if (busy !== 1'b0 || rsp_valid !== '0) begin errors++; $display("FAIL bp_release: got busy=%b valid=%b want 0", busy, rsp_valid); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int n, bad;
    bit ok;
    div_lat = 5;
    @(negedge clk);
    req_data[2*PW +: PW] = {48'd300, 48'd9};
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = '0;
    checks++; if (div_start !== 1'b1) begin errors++; $display("FAIL rm_start: got %b want 1", div_start); end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || {req_ready, rsp_valid, div_start} !== '0) begin errors++;
      $display("FAIL rm_ctrl_zero: got busy=%b valid=%b start=%b want 0", busy, rsp_valid, div_start); end
    checks++; if (div_operands !== '0 || grant_id !== 2'd0 || rsp_data !== '0) begin errors++;
      $display("FAIL rm_data_zero: got ops=%h gid=%0d data=%h want 0", div_operands, grant_id, rsp_data); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid !== '0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rm_abandoned: got %0d active cycles want 0", bad); end
    req_data[0 +: PW] = {48'd77, 48'd4};
    req_valid = 4'b0101;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rm_first_grant: got %b want 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    e.ch = 0; e.data = {48'd19, 48'd1}; e.err = 1'b0;
    exp_q.push_back(e);
    wait_rsp(30, n, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || rsp_valid !== 4'(1 << e.ch) || rsp_data !== e.data) begin errors++;
      $display("FAIL rm_rsp: got valid=%b data=%h want 0001 %h", rsp_valid, rsp_data, e.data); end
    rsp_ready = 4'b0001;
    @(negedge clk);
    rsp_ready = '0;
  endtask

  task automatic test_zero_divisor();
    exp_t e;
    int n, base;
    bit ok;
    div_lat = 4;
    @(negedge clk);
    req_data[3*PW +: PW] = {48'h55, 48'h0};
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL zd_ready: got %b want 1000", req_ready); end
    @(negedge clk);
    req_valid = '0;
    base = start_pulses;
`ifdef DIV_SCHED_ZERO_BYPASS_EN
    checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL zd_start: got %b want 0", div_start); end
    e.ch = 3; e.data = {48'hFFFF_FFFF_FFFF, 48'h55}; e.err = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    ok = 1'b1; n = 1;
`else
    checks++; if (div_start !== 1'b1) begin errors++; $display("FAIL zd_start: got %b want 1", div_start); end
    e.ch = 3; e.data = '0; e.err = 1'b0;
    exp_q.push_back(e);
    wait_rsp(30, n, ok);
`endif
    e = exp_q.pop_front();
    checks++; if (!ok || rsp_valid !== 4'(1 << e.ch)) begin errors++; $display("FAIL zd_valid: got %b want 1000 after %0d cycles", rsp_valid, n); end
    checks++; if (rsp_data !== e.data || rsp_err !== e.err) begin errors++;
      $display("FAIL zd_data: got %h err=%b want %h err=%b", rsp_data, rsp_err, e.data, e.err); end
    rsp_ready = 4'b1000;
    @(negedge clk);
    rsp_ready = '0;
`ifdef DIV_SCHED_ZERO_BYPASS_EN
    checks++; if (start_pulses - base !== 0) begin errors++; $display("FAIL zd_start_count: got %0d want 0", start_pulses - base); end
`else
    checks++; if (start_pulses - base !== 1) begin errors++; $display("FAIL zd_start_count: got %0d want 1", start_pulses - base); end
`endif
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_zero_divisor();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
